// File: rtl/msg_pkg.sv
// Shared definitions for the message frame path: beat-0 header layout, FSM
// state encoding and frame-length arithmetic.
package msg_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned HDR_W    = 32;
    localparam int unsigned INFO_W   = 96;
    localparam int unsigned FLEN_W   = 16;
    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned BEAT_W   = 19;
    localparam int unsigned LEN_MULT = 4;

    // Beat-0 layout, MSB first: [127:96] header ... [15:0] data-field length
    typedef struct packed {
        logic [HDR_W-1:0]  header;     // [127:96]
        logic [FLEN_W-1:0] frame_len;  // [95:80]
        logic [11:0]       rsvd;       // [79:68]
        logic [3:0]        ftype;      // [67:64]
        logic [FCNT_W-1:0] frame_cnt;  // [63:48]
        logic [7:0]        src;        // [47:40]
        logic [7:0]        dst;        // [39:32]
        logic [7:0]        dtype;      // [31:24]
        logic [7:0]        chan;       // [23:16]
        logic [15:0]       dlen;       // [15:0]
    } msg_hdr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_DRAIN = 2'd2
    } msg_state_t;

    // Total beats in a frame, checksum beat included
    function automatic logic [BEAT_W-1:0] frame_beats(input logic [FLEN_W-1:0] flen);
        return (BEAT_W'(flen) + BEAT_W'(1)) * BEAT_W'(LEN_MULT);
    endfunction

endpackage

// File: rtl/msg_byte_sum16.sv
// Mod-256 sum of the 16 bytes of one beat, as a balanced single-cycle adder tree.
module msg_byte_sum16
    import msg_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        sum_c
);

    logic [7:0] lvl1 [8];
    logic [7:0] lvl2 [4];
    logic [7:0] lvl3 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = data[16*i +: 8] + data[16*i+8 +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
        end
        sum_c = lvl3[0] + lvl3[1];
    end

endmodule

// File: rtl/msg_receive_check.sv
// Receive-side frame checker: validates header, length, checksum and sequence
// of each frame and keeps saturating frame/error statistics.
module msg_receive_check
    import msg_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              msg_vld_i,
    input  logic [DATA_W-1:0] msg_data_i,
    input  logic [HDR_W-1:0]  exp_header_i,
    input  logic              clr_stat_i,
    output logic              frame_done_pulse_o,
    output logic              frame_ok_o,
    output logic              err_header_o,
    output logic              err_len_o,
    output logic              err_sum_o,
    output logic              err_seq_o,
    output logic [INFO_W-1:0] hdr_info_o,
    output logic [CNT_W-1:0]  rx_frame_cnt_o,
    output logic [CNT_W-1:0]  err_frame_cnt_o
);

    msg_state_t        state_q, state_d;
    msg_hdr_t          hdr_c;
    logic [7:0]        beat_sum_c;
    logic [7:0]        acc_q;
    logic [BEAT_W-1:0] beat_idx_q;
    logic [BEAT_W-1:0] last_idx_q;
    logic              seq_vld_q;
    logic [FCNT_W-1:0] last_fcnt_q;
    logic              seq_err_q;

    logic accept_c, add_c, done_c, bad_c;
    logic e_hdr_c, e_len_c, e_sum_c, e_seq_c;

    assign hdr_c = msg_hdr_t'(msg_data_i);

    msg_byte_sum16 u_sum (
        .data  (msg_data_i),
        .sum_c (beat_sum_c)
    );

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        add_c    = 1'b0;
        done_c   = 1'b0;
        e_hdr_c  = 1'b0;
        e_len_c  = 1'b0;
        e_sum_c  = 1'b0;
        e_seq_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (msg_vld_i) begin
                    if (hdr_c.header == exp_header_i) begin
                        accept_c = 1'b1;
                        state_d  = S_BODY;
                    end else begin
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_BODY: begin
                if (!msg_vld_i) begin
                    done_c  = 1'b1;
                    e_len_c = 1'b1;
                    e_seq_c = seq_err_q;
                    state_d = S_IDLE;
                end else if (beat_idx_q == last_idx_q) begin
                    done_c  = 1'b1;
                    e_sum_c = (msg_data_i[7:0] != acc_q) || (msg_data_i[DATA_W-1:8] != '0);
                    e_seq_c = seq_err_q;
                    state_d = S_IDLE;
                end else begin
                    add_c   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!msg_vld_i) begin
                    done_c  = 1'b1;
                    e_hdr_c = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        bad_c = e_hdr_c | e_len_c | e_sum_c;
    end

    // Per-frame context: checksum accumulator, beat position, sequence history
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q       <= '0;
            beat_idx_q  <= '0;
            last_idx_q  <= '0;
            seq_vld_q   <= 1'b0;
            last_fcnt_q <= '0;
            seq_err_q   <= 1'b0;
            hdr_info_o  <= '0;
        end else if (accept_c) begin
            acc_q       <= beat_sum_c;
            beat_idx_q  <= BEAT_W'(1);
            last_idx_q  <= frame_beats(hdr_c.frame_len) - BEAT_W'(1);
            seq_err_q   <= seq_vld_q && (hdr_c.frame_cnt != last_fcnt_q + FCNT_W'(1));
            seq_vld_q   <= 1'b1;
            last_fcnt_q <= hdr_c.frame_cnt;
            hdr_info_o  <= hdr_c[INFO_W-1:0];
        end else if (add_c) begin
            acc_q       <= acc_q + beat_sum_c;
            beat_idx_q  <= beat_idx_q + BEAT_W'(1);
        end
    end

    // Result flags and statistics; a clear in the same cycle beats an increment
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_done_pulse_o <= 1'b0;
            frame_ok_o         <= 1'b0;
            err_header_o       <= 1'b0;
            err_len_o          <= 1'b0;
            err_sum_o          <= 1'b0;
            err_seq_o          <= 1'b0;
            rx_frame_cnt_o     <= '0;
            err_frame_cnt_o    <= '0;
        end else begin
            frame_done_pulse_o <= done_c;
            frame_ok_o         <= done_c & ~bad_c;
            err_header_o       <= e_hdr_c;
            err_len_o          <= e_len_c;
            err_sum_o          <= e_sum_c;
            err_seq_o          <= e_seq_c;
            if (clr_stat_i) begin
                rx_frame_cnt_o  <= '0;
                err_frame_cnt_o <= '0;
            end else if (done_c) begin
                if (rx_frame_cnt_o != '1)
                    rx_frame_cnt_o <= rx_frame_cnt_o + CNT_W'(1);
                if (bad_c && (err_frame_cnt_o != '1))
                    err_frame_cnt_o <= err_frame_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_msg_receive_check.sv
// Scoreboard bench for msg_receive_check: directed frames push expected results,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_msg_receive_check;

    localparam int unsigned CNT_W   = 3;
    localparam logic [31:0]  EXP_HDR = 32'hEB90146F;
    localparam logic [127:0] B1      = 128'h000102030405060708090a0b0c0d0e0f;

    logic              sys_clk_i = 1'b0;
    logic              rst_n_i   = 1'b0;
    logic              msg_vld_i = 1'b0;
    logic [127:0]      msg_data_i = '0;
    logic [31:0]       exp_header_i = EXP_HDR;
    logic              clr_stat_i = 1'b0;
    logic              frame_done_pulse_o, frame_ok_o;
    logic              err_header_o, err_len_o, err_sum_o, err_seq_o;
    logic [95:0]       hdr_info_o;
    logic [CNT_W-1:0]  rx_frame_cnt_o, err_frame_cnt_o;

    msg_receive_check #(.CNT_W(CNT_W)) dut (
        .sys_clk_i          (sys_clk_i),
        .rst_n_i            (rst_n_i),
        .msg_vld_i          (msg_vld_i),
        .msg_data_i         (msg_data_i),
        .exp_header_i       (exp_header_i),
        .clr_stat_i         (clr_stat_i),
        .frame_done_pulse_o (frame_done_pulse_o),
        .frame_ok_o         (frame_ok_o),
        .err_header_o       (err_header_o),
        .err_len_o          (err_len_o),
        .err_sum_o          (err_sum_o),
        .err_seq_o          (err_seq_o),
        .hdr_info_o         (hdr_info_o),
        .rx_frame_cnt_o     (rx_frame_cnt_o),
        .err_frame_cnt_o    (err_frame_cnt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        logic             ok, eh, el, es, eq;
        logic [CNT_W-1:0] rx, er;
        logic [95:0]      hdr;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    int               dones  = 0;
    logic [CNT_W-1:0] m_rx = '0;
    logic [CNT_W-1:0] m_er = '0;
    logic [95:0]      m_hdr = '0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected result of the next termination, with saturating/clearable counters
    function automatic void push_exp(input bit eh, input bit el, input bit es, input bit eq, input bit clr);
        exp_t e;
        bit   bad;
        bad = eh | el | es;
        if (clr) begin
            m_rx = '0;
            m_er = '0;
        end else begin
            if (m_rx != '1) m_rx = m_rx + 1'b1;
            if (bad && m_er != '1) m_er = m_er + 1'b1;
        end
        e.ok = !bad; e.eh = eh; e.el = el; e.es = es; e.eq = eq;
        e.rx = m_rx; e.er = m_er; e.hdr = m_hdr;
        exp_q.push_back(e);
    endfunction

    always @(negedge sys_clk_i) begin
        if (rst_n_i && frame_done_pulse_o) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_ok",   96'(frame_ok_o),      96'(mon_e.ok));
                chk("err_header", 96'(err_header_o),    96'(mon_e.eh));
                chk("err_len",    96'(err_len_o),       96'(mon_e.el));
                chk("err_sum",    96'(err_sum_o),       96'(mon_e.es));
                chk("err_seq",    96'(err_seq_o),       96'(mon_e.eq));
                chk("rx_cnt",     96'(rx_frame_cnt_o),  96'(mon_e.rx));
                chk("err_cnt",    96'(err_frame_cnt_o), 96'(mon_e.er));
                chk("hdr_info",   hdr_info_o,           mon_e.hdr);
            end
        end
    end

    task automatic beat(input logic [127:0] d);
        msg_vld_i  = 1'b1;
        msg_data_i = d;
        @(posedge sys_clk_i); #1;
    endtask

    task automatic gap(input int n);
        msg_vld_i  = 1'b0;
        msg_data_i = '0;
        repeat (n) begin @(posedge sys_clk_i); #1; end
    endtask

    function automatic logic [127:0] mk_b0(input logic [31:0] h, input logic [15:0] flen, input logic [15:0] cnt);
        return {h, flen, 12'h000, 4'h1, cnt, 8'h11, 8'h22, 8'h33, 8'h44, 16'h0010};
    endfunction

    function automatic logic [7:0] bsum(input logic [127:0] d);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) s = s + d[i*8 +: 8];
        return s;
    endfunction

    // Well-formed frame: beat1 = B1, remaining body beats zero, checksum last
    task automatic send_frame(input logic [15:0] cnt, input logic [15:0] flen,
                              input bit corrupt, input bit clr_last, input bit eq);
        logic [127:0] b0, bi;
        logic [7:0]   cs;
        int           l;
        b0 = mk_b0(EXP_HDR, flen, cnt);
        l  = (int'(flen) + 1) * 4;
        cs = bsum(b0);
        beat(b0);
        for (int i = 1; i < l - 1; i++) begin
            bi = (i == 1) ? B1 : '0;
            cs = cs + bsum(bi);
            beat(bi);
        end
        m_hdr = b0[95:0];
        push_exp(1'b0, 1'b0, corrupt, eq, clr_last);
        clr_stat_i = clr_last;
        beat({120'h0, 8'(cs + 8'(corrupt))});
        clr_stat_i = 1'b0;
    endtask

    logic [127:0] t_b0, bad_b0;
    int           d0;

    initial begin
        t_b0   = 128'hEB90146F_0000_0001_0005_11_22_33_44_0010;
        bad_b0 = mk_b0(32'h12345678, 16'd0, 16'd1);

        repeat (3) @(posedge sys_clk_i);
        #1;
        chk("rst_done",   96'(frame_done_pulse_o), 96'd0);
        chk("rst_ok",     96'(frame_ok_o),         96'd0);
        chk("rst_errs",   96'({err_header_o, err_len_o, err_sum_o, err_seq_o}), 96'd0);
        chk("rst_hdr",    hdr_info_o,              96'd0);
        chk("rst_rx",     96'(rx_frame_cnt_o),     96'd0);
        chk("rst_er",     96'(err_frame_cnt_o),    96'd0);
        rst_n_i = 1'b1;
        gap(2);

        // Reference 4-beat frame, hand checksum 0x36
        m_hdr = t_b0[95:0];
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(t_b0); beat(B1); beat('0); beat(128'h36);
        gap(2);
        chk("t1_rx", 96'(rx_frame_cnt_o), 96'd1);

        // Same frame with bad checksum; frame_cnt repeats so err_seq is also set
        push_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(t_b0); beat(B1); beat('0); beat(128'h37);
        gap(2);
        chk("t2_er", 96'(err_frame_cnt_o), 96'd1);

        // Short frame: vld drops after beat 2
        t_b0  = mk_b0(EXP_HDR, 16'd0, 16'd6);
        m_hdr = t_b0[95:0];
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(t_b0); beat(B1); beat('0);
        gap(1);
        chk("len_done_timing", 96'(frame_done_pulse_o), 96'd1);
        gap(2);

        // Wrong header held for 3 beats
        d0 = dones;
        push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(bad_b0); beat(bad_b0); beat(bad_b0);
        chk("hdr_no_early_done", 96'(frame_done_pulse_o), 96'd0);
        gap(1);
        chk("hdr_done_timing", 96'(frame_done_pulse_o), 96'd1);
        gap(3);
        chk("hdr_single_done", 96'(dones - d0), 96'd1);

        // Reset in the middle of a frame
        d0 = dones;
        beat(mk_b0(EXP_HDR, 16'd0, 16'd10));
        msg_vld_i  = 1'b1;
        msg_data_i = B1;
        rst_n_i    = 1'b0;
        @(posedge sys_clk_i); #1;
        msg_vld_i  = 1'b0;
        @(posedge sys_clk_i); #1;
        rst_n_i = 1'b1;
        m_rx = '0; m_er = '0; m_hdr = '0;
        gap(3);
        chk("rst_mid_no_done", 96'(dones - d0), 96'd0);
        chk("rst_mid_rx",  96'(rx_frame_cnt_o),  96'd0);
        chk("rst_mid_er",  96'(err_frame_cnt_o), 96'd0);
        chk("rst_mid_hdr", hdr_info_o,           96'd0);
        send_frame(16'd4, 16'd0, 1'b0, 1'b0, 1'b0);
        gap(2);

        // Back-to-back frames, 5 then 7 (second is 8 beats long)
        d0 = dones;
        send_frame(16'd5, 16'd0, 1'b0, 1'b0, 1'b0);
        send_frame(16'd7, 16'd1, 1'b0, 1'b0, 1'b1);
        gap(2);
        chk("b2b_dones", 96'(dones - d0), 96'd2);

        // Clear coincident with a termination
        send_frame(16'd8, 16'd0, 1'b0, 1'b1, 1'b0);
        gap(2);
        chk("clr_win_rx", 96'(rx_frame_cnt_o), 96'd0);

        // Saturation of both counters with minimal bad-header frames
        for (int i = 0; i < 9; i++) begin
            push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            beat(bad_b0);
            gap(1);
        end
        gap(2);
        chk("sat_rx", 96'(rx_frame_cnt_o),  96'(3'd7));
        chk("sat_er", 96'(err_frame_cnt_o), 96'(3'd7));

        // Plain clear
        clr_stat_i = 1'b1;
        @(posedge sys_clk_i); #1;
        clr_stat_i = 1'b0;
        chk("clr_rx", 96'(rx_frame_cnt_o),  96'd0);
        chk("clr_er", 96'(err_frame_cnt_o), 96'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge sys_clk_i); #1;
        end
        chk("queue_drained", 96'(exp_q.size()), 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
